// File: rtl/ins_prefetch_queue_pkg.sv
// Shared pipeline constants for the fetch/decode boundary: idle instruction word,
// default queue depth and the pointer-width helper.
package ins_prefetch_queue_pkg;

  localparam logic [31:0] NOP_INS       = 32'd0;
  localparam int          DEFAULT_DEPTH = 4;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/ins_queue_ram.sv
// Prefetch queue storage: one synchronous write port, one asynchronous read port.
// Storage is never reset; occupancy tracking in the parent decides which entries are live.
module ins_queue_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int PTR_W = 2
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ins_prefetch_queue.sv
// Instruction prefetch queue between i-cache and decode, with one-cycle flush on redirect.
// Optional 0-latency empty-queue bypass when PREFETCH_BYPASS_EN is defined.
module ins_prefetch_queue
  import ins_prefetch_queue_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        FLUSH,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  input  logic [DATA_WIDTH-1:0]       IN_INS,
  input  logic [ADDR_WIDTH-1:0]       IN_PC,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic [DATA_WIDTH-1:0]       OUT_INS,
  output logic [ADDR_WIDTH-1:0]       OUT_PC,
  output logic [$clog2(DEPTH):0]      COUNT
);

  localparam int PTR_W   = ptr_width(DEPTH);
  localparam int COUNT_W = PTR_W + 1;
  localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH;

  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [COUNT_W-1:0] r_count;

  logic               w_empty;
  logic               w_bypass;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_rdata;

  assign w_empty  = (r_count == '0);
  assign IN_READY = !RST && (r_count < COUNT_W'(DEPTH));

`ifdef PREFETCH_BYPASS_EN
  assign w_bypass = w_empty && IN_VALID && !FLUSH && !RST;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed entry taken by decode in the same cycle never lands in storage.
  assign w_push    = IN_VALID && IN_READY && !(w_bypass && OUT_READY);
  assign w_pop     = OUT_READY && !w_empty;
  assign OUT_VALID = !w_empty || w_bypass;
  assign COUNT     = r_count;

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  ins_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .PTR_W (PTR_W)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata ({IN_PC, IN_INS}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // All-zero output is the decoder's idle word, so never expose stale storage.
  always_comb begin
    OUT_INS = DATA_WIDTH'(NOP_INS);
    OUT_PC  = '0;
    if (!w_empty) begin
      OUT_INS = w_rdata[DATA_WIDTH-1:0];
      OUT_PC  = w_rdata[ENTRY_W-1:DATA_WIDTH];
    end else if (w_bypass) begin
      OUT_INS = IN_INS;
      OUT_PC  = IN_PC;
    end
  end

endmodule

// File: tb/tb_ins_prefetch_queue.sv
// Directed self-checking bench for ins_prefetch_queue (DEPTH=4); follows PREFETCH_BYPASS_EN
// for the same-cycle bypass expectations.
module tb_ins_prefetch_queue;

  logic        CLK = 1'b0;
  logic        RST;
  logic        FLUSH;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_INS;
  logic [31:0] IN_PC;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_INS;
  logic [31:0] OUT_PC;
  logic [2:0]  COUNT;

  int n_checks = 0;
  int n_fail   = 0;

  ins_prefetch_queue #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .FLUSH     (FLUSH),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_INS    (IN_INS),
    .IN_PC     (IN_PC),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_INS   (OUT_INS),
    .OUT_PC    (OUT_PC),
    .COUNT     (COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later still.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return 32'hA500_0000 | pc;
  endfunction

  task automatic push(input logic [31:0] pc);
    IN_VALID = 1'b1;
    IN_PC    = pc;
    IN_INS   = ins_of(pc);
    tick();
    IN_VALID = 1'b0;
  endtask

  initial begin
    RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    IN_INS = '0; IN_PC = '0;
    #1;
    tick(); tick();
    #1;
    check("rst_count",     64'(COUNT),     64'd0);
    check("rst_out_valid", 64'(OUT_VALID), 64'd0);
    check("rst_out_ins",   64'(OUT_INS),   64'd0);
    check("rst_out_pc",    64'(OUT_PC),    64'd0);
    check("rst_in_ready",  64'(IN_READY),  64'd0);
    RST = 1'b0;
    tick();
    #1;
    check("post_rst_in_ready", 64'(IN_READY), 64'd1);

    // in-order fill and drain
    push(32'h0); push(32'h4); push(32'h8);
    #1;
    check("fill3_count",  64'(COUNT),     64'd3);
    check("fill3_head",   64'(OUT_PC),    64'h0);
    check("fill3_valid",  64'(OUT_VALID), 64'd1);
    OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("drain_pc",  64'(OUT_PC),  64'(32'(4 * i)));
      check("drain_ins", 64'(OUT_INS), 64'(ins_of(32'(4 * i))));
      tick();
    end
    OUT_READY = 1'b0;
    #1;
    check("empty_count", 64'(COUNT),     64'd0);
    check("empty_ins",   64'(OUT_INS),   64'd0);
    check("empty_pc",    64'(OUT_PC),    64'd0);
    check("empty_valid", 64'(OUT_VALID), 64'd0);

    // full boundary
    push(32'h10); push(32'h14); push(32'h18); push(32'h1C);
    #1;
    check("full_count",    64'(COUNT),    64'd4);
    check("full_in_ready", 64'(IN_READY), 64'd0);
    IN_VALID = 1'b1; IN_PC = 32'h20; IN_INS = ins_of(32'h20);
    tick();
    check("full_ignore_count", 64'(COUNT),  64'd4);
    check("full_head_kept",    64'(OUT_PC), 64'h10);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    #1;
    check("pop_full_count",    64'(COUNT),    64'd3);
    check("pop_full_in_ready", 64'(IN_READY), 64'd1);
    check("pop_full_head",     64'(OUT_PC),   64'h14);
    tick();
    IN_VALID = 1'b0;
    #1;
    check("fifth_push_count", 64'(COUNT), 64'd4);
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("full_drain_pc", 64'(OUT_PC), 64'(32'h14 + 32'(4 * i)));
      tick();
    end
    OUT_READY = 1'b0;
    #1;
    check("full_drain_count", 64'(COUNT), 64'd0);

    // streaming with pointer wrap
    for (int i = 0; i < 20; i++) begin
      IN_VALID  = 1'b1;
      IN_PC     = 32'h100 + 32'(4 * i);
      IN_INS    = ins_of(IN_PC);
      OUT_READY = (i >= 2);
      #1;
      if (i >= 2) begin
        check("stream_pc",    64'(OUT_PC),  64'(32'h100 + 32'(4 * (i - 2))));
        check("stream_count", 64'(COUNT),   64'd2);
      end
      tick();
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    for (int i = 18; i < 20; i++) begin
      #1;
      check("stream_tail_pc", 64'(OUT_PC), 64'(32'h100 + 32'(4 * i)));
      tick();
    end
    OUT_READY = 1'b0;
    #1;
    check("stream_end_count", 64'(COUNT), 64'd0);

    // flush beats push and pop in the same cycle
    push(32'h1000); push(32'h1004); push(32'h1008);
    FLUSH = 1'b1; IN_VALID = 1'b1; IN_PC = 32'h3000; IN_INS = ins_of(32'h3000); OUT_READY = 1'b1;
    tick();
    FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    #1;
    check("flush_count",    64'(COUNT),     64'd0);
    check("flush_valid",    64'(OUT_VALID), 64'd0);
    check("flush_in_ready", 64'(IN_READY),  64'd1);
    push(32'h2000);
    #1;
    check("post_flush_head",  64'(OUT_PC), 64'h2000);
    check("post_flush_count", 64'(COUNT),  64'd1);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;

    // reset mid-stream
    push(32'h40); push(32'h44);
    RST = 1'b1;
    tick();
    #1;
    check("mid_rst_count",    64'(COUNT),     64'd0);
    check("mid_rst_valid",    64'(OUT_VALID), 64'd0);
    check("mid_rst_ins",      64'(OUT_INS),   64'd0);
    check("mid_rst_pc",       64'(OUT_PC),    64'd0);
    check("mid_rst_in_ready", 64'(IN_READY),  64'd0);
    RST = 1'b0;
    tick();
    push(32'h80);
    #1;
    check("after_rst_head",  64'(OUT_PC), 64'h80);
    check("after_rst_count", 64'(COUNT),  64'd1);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;

    // empty-queue latency, bypass or not
    IN_VALID = 1'b1; IN_PC = 32'h200; IN_INS = 32'h0050_0093; OUT_READY = 1'b1;
    #1;
`ifdef PREFETCH_BYPASS_EN
    check("byp_same_ins",   64'(OUT_INS),   64'h0050_0093);
    check("byp_same_valid", 64'(OUT_VALID), 64'd1);
`else
    check("nobyp_same_ins",   64'(OUT_INS),   64'd0);
    check("nobyp_same_valid", 64'(OUT_VALID), 64'd0);
`endif
    tick();
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    #1;
`ifdef PREFETCH_BYPASS_EN
    check("byp_next_count", 64'(COUNT),   64'd0);
    check("byp_next_ins",   64'(OUT_INS), 64'd0);
`else
    check("nobyp_next_count", 64'(COUNT),   64'd1);
    check("nobyp_next_ins",   64'(OUT_INS), 64'h0050_0093);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
